// File: rtl/wr_addr_gen.sv
// wr_addr_gen: FIFO write pointer/address generator with full, almost_full, level and overflow logging
module wr_addr_gen #(
  parameter int FIFO_PTR_WIDE = 3,
  parameter int AFULL_THRESH  = 6,
  parameter int DROP_CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [FIFO_PTR_WIDE:0]  rd_ptr,
  input  logic                    clr_ovf,
  output logic [FIFO_PTR_WIDE-1:0] wr_addr,
  output logic [FIFO_PTR_WIDE:0]  wr_ptr,
  output logic                    full,
  output logic                    almost_full,
  output logic [FIFO_PTR_WIDE:0]  level,
  output logic                    wr_ack,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);
  localparam int W = FIFO_PTR_WIDE;
  localparam logic [W:0] AF = (W+1)'(AFULL_THRESH);
  logic wr_acc;
  assign wr_addr     = wr_ptr[W-1:0];
  assign full        = (wr_ptr[W] != rd_ptr[W]) && (wr_ptr[W-1:0] == rd_ptr[W-1:0]);
  assign level       = wr_ptr - rd_ptr;
  assign almost_full = level >= AF;
  assign wr_acc      = wr_en & ~full;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      wr_ack   <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + (W+1)'(wr_acc);
      wr_ack <= wr_acc;
      // clear wins over a reject landing on the same edge
      if (clr_ovf) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (wr_en && full) begin
        overflow <= 1'b1;
        drop_cnt <= drop_cnt + DROP_CNT_W'(drop_cnt != '1);
      end
    end
  end
endmodule

// File: tb/tb_wr_addr_gen.sv
// tb_wr_addr_gen: directed checks of wr_addr_gen with hand-computed expectations
module tb_wr_addr_gen;
  logic       clk = 1'b0;
  logic       rst_n, wr_en, clr_ovf;
  logic [3:0] rd_ptr;
  logic [2:0] wr_addr;
  logic [3:0] wr_ptr, level;
  logic       full, almost_full, wr_ack, overflow;
  logic [7:0] drop_cnt;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  wr_addr_gen #(.FIFO_PTR_WIDE(3), .AFULL_THRESH(6), .DROP_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_ptr(rd_ptr), .clr_ovf(clr_ovf),
    .wr_addr(wr_addr), .wr_ptr(wr_ptr), .full(full), .almost_full(almost_full),
    .level(level), .wr_ack(wr_ack), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; clr_ovf = 1'b0; rd_ptr = 4'd0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    // fill 8 entries with rd_ptr held at 0
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("fill_wr_addr", wr_addr, i);
      check("fill_level", level, i);
      check("fill_afull", almost_full, (i >= 6) ? 1 : 0);
      check("fill_full", full, 0);
      @(negedge clk);
      check("fill_wr_ack", wr_ack, 1);
    end
    check("fill_wr_ptr", wr_ptr, 4'b1000);
    check("fill_full_end", full, 1);
    check("fill_level_end", level, 8);
    check("fill_afull_end", almost_full, 1);
    // writes into a full FIFO
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("ovf_wr_ack", wr_ack, 0);
      check("ovf_wr_ptr", wr_ptr, 4'b1000);
      check("ovf_overflow", overflow, 1);
      check("ovf_drop_cnt", drop_cnt, k);
    end
    wr_en = 1'b0; clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("clr_overflow", overflow, 0);
    check("clr_drop_cnt", drop_cnt, 0);
    check("clr_wr_ptr", wr_ptr, 4'b1000);
    // reject and clear on the same edge
    wr_en = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0; wr_en = 1'b0;
    check("clrpri_overflow", overflow, 0);
    check("clrpri_drop_cnt", drop_cnt, 0);
    // read advances on the same edge as a write into full
    wr_en = 1'b1;
    @(posedge clk);
    #1 rd_ptr = 4'd1;
    @(negedge clk);
    check("sim_drop_cnt", drop_cnt, 1);
    check("sim_overflow", overflow, 1);
    check("sim_wr_ack", wr_ack, 0);
    check("sim_wr_ptr", wr_ptr, 4'b1000);
    check("sim_full", full, 0);
    check("sim_level", level, 7);
    @(negedge clk);
    wr_en = 1'b0;
    check("retry_wr_ack", wr_ack, 1);
    check("retry_wr_ptr", wr_ptr, 4'b1001);
    check("retry_full", full, 1);
    // move to wr_ptr=1010, rd_ptr=0011
    rd_ptr = 4'd2; wr_en = 1'b1;
    @(negedge clk);
    rd_ptr = 4'b0011;
    #1 check("wrap_wr_addr", wr_addr, 2);
    check("wrap_pre_level", level, 7);
    @(negedge clk);
    wr_en = 1'b0;
    check("wrap_wr_ptr", wr_ptr, 4'b1011);
    check("wrap_full", full, 1);
    check("wrap_level", level, 8);
    rd_ptr = 4'b0100;
    #1 check("wrap_rd_full", full, 0);
    check("wrap_rd_level", level, 7);
    // all-ones pointer rolls over to zero
    rd_ptr = 4'b1011; wr_en = 1'b1;
    repeat (5) @(negedge clk);
    wr_en = 1'b0;
    check("roll_wr_ptr", wr_ptr, 0);
    check("roll_wr_addr", wr_addr, 0);
    check("roll_level", level, 5);
    check("roll_full", full, 0);
    // async reset mid-stream at wr_ptr=5 with a pending wr_ack
    rd_ptr = 4'd0;
    wr_en = 1'b1;
    repeat (5) @(negedge clk);
    wr_en = 1'b0;
    check("pre_rst_wr_ptr", wr_ptr, 5);
    check("pre_rst_wr_ack", wr_ack, 1);
    check("pre_rst_overflow", overflow, 1);
    #2 rst_n = 1'b0;
    #1 check("arst_wr_ptr", wr_ptr, 0);
    check("arst_wr_ack", wr_ack, 0);
    check("arst_overflow", overflow, 0);
    check("arst_drop_cnt", drop_cnt, 0);
    check("arst_level", level, 0);
    #10 rst_n = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
